// File: rtl/pmem_burst_adaptor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adaptor_pkg
// Purpose  : Shared widths and FSM state encoding for pmem_burst_adaptor.
//            A 256-bit cache line is carried as four 64-bit memory beats;
//            burst addresses are aligned to the 32-byte line (5 offset bits).
// Revision : 1.0 - initial release
// ============================================================================
package adaptor_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned NUM_BEATS   = LINE_W / BEAT_W;
  localparam int unsigned OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : adaptor_pkg
`default_nettype wire

// File: rtl/pmem_burst_adaptor_if.sv
`default_nettype none
// ============================================================================
// Module   : pmem_burst_adaptor_if
// Purpose  : Bundles the cache-side line request bus and the memory-side
//            burst bus seen by the adaptor. Signal directions are named from
//            the adaptor's point of view.
// Modports : slave  - the adaptor (drives *_o, samples *_i)
//            master - the environment: cache and memory (drives *_i)
// Signals  : line_i/line_o (256), address_i (32), read_i, write_i,
//            resp_o, err_o, burst_i/burst_o (64), address_o (32),
//            read_o, write_o, resp_i
// Revision : 1.0 - initial release
// ============================================================================
interface pmem_burst_adaptor_if;
  import adaptor_pkg::*;

  // cache side
  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic [31:0]       address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic              err_o;

  // memory side
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, err_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, err_o, burst_o, address_o, read_o, write_o
  );

endinterface : pmem_burst_adaptor_if
`default_nettype wire

// File: rtl/pmem_burst_adaptor_beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : beat_counter
// Purpose  : 2-bit beat index for a 4-beat burst. Wraps 3->0 on the final
//            increment, so it is back at zero on entry to DONE.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            clr_i      - force count to zero (has priority over inc_i)
//            inc_i      - advance by one beat
//            count_o    - current beat index
//            last_o     - current index is the final beat of the burst
// Revision : 1.0 - initial release
// ============================================================================
module beat_counter
  import adaptor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [1:0] count_o,
  output logic       last_o
);

  logic [1:0] count_q;
  logic [1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 2'd0;
    end else if (inc_i) begin
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == 2'(NUM_BEATS - 1));

endmodule : beat_counter
`default_nettype wire

// File: rtl/pmem_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : pmem_burst_adaptor
// Purpose  : Converts single 256-bit cache line reads/writes into 4-beat
//            64-bit physical-memory bursts. One transaction in flight; the
//            cache holds its request until resp_o pulses for one cycle.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - pmem_burst_adaptor_if.slave (cache + memory buses)
// Macro    : ADAPTOR_TIMEOUT_EN - when defined, a burst that sees no beat
//            strobe for TIMEOUT_CYCLES consecutive cycles is aborted with
//            err_o=1 alongside resp_o. When undefined err_o is tied low and
//            the FSM waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_burst_adaptor
  import adaptor_pkg::*;
`ifdef ADAPTOR_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
  input  logic                clk,
  input  logic                rst,
  pmem_burst_adaptor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(LINE_W);

  state_t            state_q;
  logic [LINE_W-1:0] line_q;   // assembled read line, held between reads
  logic [LINE_W-1:0] wbuf_q;   // write line, shifted down one beat per strobe
  logic [BEAT_W-1:0] burst_q;
  logic [31:0]       addr_q;
  logic              rd_q;
  logic              wr_q;
  logic              resp_q;

  logic              in_burst;
  logic              beat_acc;
  logic [1:0]        beat_cnt;
  logic              beat_last;
  logic [IDX_W-1:0]  beat_lsb;
  logic              abort;
  logic              unused_addr_bits;

  // Strobes outside RD/WR are ignored entirely, including by the counter.
  assign in_burst = (state_q == RD) || (state_q == WR);
  assign beat_acc = in_burst && bus.resp_i;
  assign beat_lsb = {beat_cnt, {(IDX_W - 2){1'b0}}};

  assign unused_addr_bits = ^bus.address_i[OFFSET_BITS-1:0];

  beat_counter u_beat_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == IDLE),
    .inc_i   (beat_acc),
    .count_o (beat_cnt),
    .last_o  (beat_last)
  );

`ifdef ADAPTOR_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_q;
  logic            err_q;

  // Counts consecutive strobe-less burst cycles; any strobe restarts it.
  always_ff @(posedge clk) begin
    if (rst || !in_burst || bus.resp_i) begin
      to_q <= '0;
    end else begin
      to_q <= to_q + 1'b1;
    end
  end

  assign abort     = in_burst && !bus.resp_i && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign bus.err_o = err_q;
`else
  assign abort     = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      wbuf_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
`ifdef ADAPTOR_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      resp_q <= 1'b0;
`ifdef ADAPTOR_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // Write wins a tie so a dirty eviction goes out before the fill.
          if (bus.write_i) begin
            addr_q  <= {bus.address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            wbuf_q  <= bus.line_i;
            burst_q <= bus.line_i[BEAT_W-1:0];
            wr_q    <= 1'b1;
            state_q <= WR;
          end else if (bus.read_i) begin
            addr_q  <= {bus.address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            rd_q    <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            line_q[beat_lsb +: BEAT_W] <= bus.burst_i;
            if (beat_last) begin
              rd_q    <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WR: begin
          if (bus.resp_i) begin
            wbuf_q  <= wbuf_q >> BEAT_W;
            burst_q <= wbuf_q[2*BEAT_W-1 -: BEAT_W];
            if (beat_last) begin
              wr_q    <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (abort) begin
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
        resp_q  <= 1'b1;
`ifdef ADAPTOR_TIMEOUT_EN
        err_q   <= 1'b1;
`endif
        state_q <= DONE;
      end
    end
  end

  assign bus.line_o    = line_q;
  assign bus.burst_o   = burst_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = rd_q;
  assign bus.write_o   = wr_q;
  assign bus.resp_o    = resp_q;

endmodule : pmem_burst_adaptor
`default_nettype wire

// File: tb/tb_pmem_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_burst_adaptor
// Purpose  : Self-checking bench for pmem_burst_adaptor. The bench acts as
//            both cache and memory; expected lines and beats are queued when
//            stimulus is driven and popped when the DUT presents them.
// Macro    : ADAPTOR_TIMEOUT_EN - also runs the abort scenario with
//            TIMEOUT_CYCLES=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_burst_adaptor;
  import adaptor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmem_burst_adaptor_if bus();

`ifdef ADAPTOR_TIMEOUT_EN
  pmem_burst_adaptor #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  pmem_burst_adaptor dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int total = 0;
  int bad   = 0;

  logic [LINE_W-1:0] exp_lines[$];
  logic [BEAT_W-1:0] exp_beats[$];
  logic [LINE_W-1:0] held_line = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_read(input logic [31:0] addr, input logic [LINE_W-1:0] line, input int gap);
    logic [LINE_W-1:0] exp;
    logic [31:0]       exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    bus.read_i    = 1'b1;
    bus.address_i = addr;
    exp_lines.push_back(line);
    step();
    total++;
    if (bus.read_o !== 1'b1 || bus.write_o !== 1'b0 || bus.address_o !== exp_addr) begin
      bad++;
      $display("FAIL rd_start: read_o=%b write_o=%b address_o=%h, required 1 0 %h",
               bus.read_o, bus.write_o, bus.address_o, exp_addr);
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        bus.burst_i = {$urandom, $urandom};
        total++;
        if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin
          bad++;
          $display("FAIL rd_gap beat %0d: read_o=%b resp_o=%b, required 1 0", k, bus.read_o, bus.resp_o);
        end
        step();
      end
      bus.resp_i  = 1'b1;
      bus.burst_i = line[k*BEAT_W +: BEAT_W];
      step();
      bus.resp_i  = 1'b0;
      bus.burst_i = {$urandom, $urandom};
      if (k < 3) begin
        total++;
        if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin
          bad++;
          $display("FAIL rd_beat %0d: read_o=%b resp_o=%b, required 1 0", k, bus.read_o, bus.resp_o);
        end
      end
    end
    exp = exp_lines.pop_front();
    total++;
    if (bus.resp_o !== 1'b1 || bus.read_o !== 1'b0 || bus.err_o !== 1'b0 || bus.line_o !== exp) begin
      bad++;
      $display("FAIL rd_done: resp_o=%b read_o=%b err_o=%b line_o=%h, required 1 0 0 %h",
               bus.resp_o, bus.read_o, bus.err_o, bus.line_o, exp);
    end
    held_line  = exp;
    bus.read_i = 1'b0;
    step();
    total++;
    if (bus.resp_o !== 1'b0 || bus.line_o !== held_line) begin
      bad++;
      $display("FAIL rd_after: resp_o=%b line_o=%h, required 0 %h", bus.resp_o, bus.line_o, held_line);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [LINE_W-1:0] line, input int gap,
                          input logic also_read);
    logic [BEAT_W-1:0] b;
    logic [31:0]       exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    bus.write_i   = 1'b1;
    bus.read_i    = also_read;
    bus.address_i = addr;
    bus.line_i    = line;
    for (int k = 0; k < 4; k++) exp_beats.push_back(line[k*BEAT_W +: BEAT_W]);
    step();
    bus.line_i = rand_line();
    total++;
    if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0 || bus.address_o !== exp_addr) begin
      bad++;
      $display("FAIL wr_start: write_o=%b read_o=%b address_o=%h, required 1 0 %h",
               bus.write_o, bus.read_o, bus.address_o, exp_addr);
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        total++;
        if (bus.write_o !== 1'b1 || bus.resp_o !== 1'b0 || bus.burst_o !== exp_beats[0]) begin
          bad++;
          $display("FAIL wr_gap beat %0d: write_o=%b resp_o=%b burst_o=%h, required 1 0 %h",
                   k, bus.write_o, bus.resp_o, bus.burst_o, exp_beats[0]);
        end
        step();
      end
      b = exp_beats.pop_front();
      total++;
      if (bus.burst_o !== b || bus.write_o !== 1'b1 || bus.read_o !== 1'b0) begin
        bad++;
        $display("FAIL wr_beat %0d: burst_o=%h write_o=%b read_o=%b, required %h 1 0",
                 k, bus.burst_o, bus.write_o, bus.read_o, b);
      end
      bus.resp_i = 1'b1;
      step();
      bus.resp_i = 1'b0;
    end
    total++;
    if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0 || bus.read_o !== 1'b0 ||
        bus.err_o !== 1'b0 || bus.line_o !== held_line) begin
      bad++;
      $display("FAIL wr_done: resp_o=%b write_o=%b read_o=%b err_o=%b line_o=%h, required 1 0 0 0 %h",
               bus.resp_o, bus.write_o, bus.read_o, bus.err_o, bus.line_o, held_line);
    end
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    step();
    total++;
    if (bus.resp_o !== 1'b0 || bus.write_o !== 1'b0) begin
      bad++;
      $display("FAIL wr_after: resp_o=%b write_o=%b, required 0 0", bus.resp_o, bus.write_o);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (bus.line_o !== '0 || bus.burst_o !== '0 || bus.address_o !== '0 || bus.read_o !== 1'b0 ||
        bus.write_o !== 1'b0 || bus.resp_o !== 1'b0 || bus.err_o !== 1'b0) begin
      bad++;
      $display("FAIL %s: addr=%h rd=%b wr=%b resp=%b err=%b burst=%h line_nonzero=%b, required all zero",
               tag, bus.address_o, bus.read_o, bus.write_o, bus.resp_o, bus.err_o, bus.burst_o,
               |bus.line_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    step();
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_read();
    do_read(32'h1234_5678, {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}}, 0);
    total++;
    if (bus.address_o !== 32'h1234_5660) begin
      bad++;
      $display("FAIL rd_addr_const: address_o=%h, required 12345660", bus.address_o);
    end
  endtask

  task automatic test_write();
    do_write(32'h0000_1F3F, {{32{4'hA}}, {32{4'h5}}}, 0, 1'b0);
    do_write($urandom, rand_line(), 1, 1'b0);
  endtask

  task automatic test_gaps();
    do_read($urandom, {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}}, 2);
  endtask

  task automatic test_both();
    do_write(32'hDEAD_BEEF, rand_line(), 0, 1'b1);
  endtask

  task automatic test_idle_resp();
    for (int i = 0; i < 3; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      step();
      total++;
      if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0 || bus.line_o !== held_line) begin
        bad++;
        $display("FAIL idle_resp: read_o=%b write_o=%b resp_o=%b line_changed=%b, required 0 0 0 0",
                 bus.read_o, bus.write_o, bus.resp_o, bus.line_o !== held_line);
      end
    end
    bus.resp_i = 1'b0;
    do_read($urandom, rand_line(), 1);
  endtask

  task automatic test_back_to_back();
    do_read($urandom, rand_line(), 0);
    do_write($urandom, rand_line(), 0, 1'b0);
    do_read($urandom, rand_line(), 0);
  endtask

  task automatic test_reset_mid();
    logic [LINE_W-1:0] line;
    line          = rand_line();
    bus.read_i    = 1'b1;
    bus.address_i = $urandom;
    step();
    for (int k = 0; k < 3; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = line[k*BEAT_W +: BEAT_W];
      step();
    end
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    rst        = 1'b1;
    step();
    check_reset_outputs("reset_mid_burst");
    rst       = 1'b0;
    held_line = '0;
    step();
    total++;
    if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_resp: resp_o=%b read_o=%b, required 0 0", bus.resp_o, bus.read_o);
    end
    do_read($urandom, rand_line(), 0);
  endtask

`ifdef ADAPTOR_TIMEOUT_EN
  task automatic test_timeout();
    bus.read_i    = 1'b1;
    bus.address_i = $urandom;
    step();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b1) begin
        bad++;
        $display("FAIL to_wait %0d: resp_o=%b read_o=%b, required 0 1", i, bus.resp_o, bus.read_o);
      end
      step();
    end
    total++;
    if (bus.resp_o !== 1'b1 || bus.err_o !== 1'b1 || bus.read_o !== 1'b0) begin
      bad++;
      $display("FAIL to_abort: resp_o=%b err_o=%b read_o=%b, required 1 1 0", bus.resp_o, bus.err_o, bus.read_o);
    end
    bus.read_i = 1'b0;
    step();
    total++;
    if (bus.resp_o !== 1'b0 || bus.err_o !== 1'b0 || bus.read_o !== 1'b0) begin
      bad++;
      $display("FAIL to_after: resp_o=%b err_o=%b read_o=%b, required 0 0 0", bus.resp_o, bus.err_o, bus.read_o);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_gaps();
    test_both();
    test_idle_resp();
    test_back_to_back();
    test_reset_mid();
`ifdef ADAPTOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pmem_burst_adaptor
`default_nettype wire
